multiply_sequencer: RTL

MULTIPLY_SEQUENCER -- requirements
Module: multiply_sequencer

---
 rtl/mult_seq_pkg.sv | 15 +
 rtl/full_adder_32.sv | 37 +++
 rtl/multiply_sequencer.sv | 85 ++++++++
 3 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the shift-add multiply sequencer.
// The adder lane count and the iteration count are both tied to the operand width.
package mult_seq_pkg;

   localparam int DATA_W          = 32;
   localparam int MULT_ITERATIONS = 32;
   localparam int CNT_W           = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder_32.sv
// 32-bit ripple-carry adder built from one full-adder cell per bit lane.
// There is no carry-out: sums wrap modulo 2^32.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module full_adder_32
   import mult_seq_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] sum
);
   logic [DATA_W-1:0] carry;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < DATA_W-1; i++) begin : g_lane
      full_adder_bit u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .sum  (sum[i]),
         .cout (carry[i+1])
      );
   end

   // Top lane drops its carry, which gives the modulo-2^32 wrap.
   assign sum[DATA_W-1] = a[DATA_W-1] ^ b[DATA_W-1] ^ carry[DATA_W-1];
endmodule

// File: rtl/multiply_sequencer.sv
// Sequential unsigned 32x32 multiplier (low 32 product bits), one shift-add per RUN cycle.
// Always runs 32 iterations, then holds a one-cycle DONE before returning to IDLE.
module multiply_sequencer
   import mult_seq_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] multiplicand,
   input  logic [DATA_W-1:0] multiplier,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   state_t            state, state_n;
   logic [DATA_W-1:0] mcand, mq, acc;
   logic [DATA_W-1:0] add_sum, acc_next;
   logic [CNT_W-1:0]  count;
   logic              load, step, last;

   assign last = (count == CNT_W'(MULT_ITERATIONS-1));

   full_adder_32 u_add (
      .a   (acc),
      .b   (mcand),
      .sum (add_sum)
   );

   // Only accumulate the shifted multiplicand when the current multiplier bit is set.
   assign acc_next = mq[0] ? add_sum : acc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = IDLE;
      load    = 1'b0;
      step    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE: begin
            load    = start;
            state_n = start ? RUN : IDLE;
         end
         RUN: begin
            busy    = 1'b1;
            step    = 1'b1;
            state_n = last ? DONE : RUN;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mcand   <= '0;
         mq      <= '0;
         acc     <= '0;
         count   <= '0;
         product <= '0;
      end else if (load) begin
         mcand <= multiplicand;
         mq    <= multiplier;
         acc   <= '0;
         count <= '0;
      end else if (step) begin
         acc   <= acc_next;
         mcand <= {mcand[DATA_W-2:0], 1'b0};
         mq    <= {1'b0, mq[DATA_W-1:1]};
         count <= count + CNT_W'(1);
         // Product is published only on the final iteration, never mid-run.
         if (last) product <= acc_next;
      end
   end

endmodule
